// File: rtl/constants_pkg.sv
// Shared widths, depths and feeder state encoding for the matrix core stream interface.
package constants_pkg;
    localparam int DATA_WIDTH        = 8;
    localparam int ACC_WIDTH         = 32;
    localparam int MAT_DIM           = 4;
    localparam int W_DEPTH           = MAT_DIM * MAT_DIM;
    localparam int X_DEPTH           = MAT_DIM;
    localparam int BUF_DEPTH         = W_DEPTH + X_DEPTH;
    localparam int BUF_ADDR_WIDTH    = 5;
    localparam int RESULT_ADDR_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_W  = 3'd1,
        SEND_X  = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4
    } feeder_state_t;
endpackage

// File: rtl/feeder_buf.sv
// Host-loaded W/X word store: 20 entries, one write port, one combinational indexed read port.
module feeder_buf
    import constants_pkg::*;
(
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [BUF_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [BUF_ADDR_WIDTH-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0]     rd_word
);
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];

    // Contents survive reset so a job can be re-run after an abort.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < BUF_ADDR_WIDTH'(BUF_DEPTH))) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_idx < BUF_ADDR_WIDTH'(BUF_DEPTH)) begin
            rd_word = mem[rd_idx];
        end
    end
endmodule

// File: rtl/matrix_feeder.sv
// Host-side feeder: streams 16 W words then 4 X words to the matrix core, then collects MAT_DIM results.
module matrix_feeder
    import constants_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [BUF_ADDR_WIDTH-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         start,
    output logic                         src_vld,
    output logic [DATA_WIDTH-1:0]        src_data,
    input  logic                         src_rdy,
    input  logic                         snk_vld,
    input  logic [ACC_WIDTH-1:0]         snk_data,
    output logic                         snk_rdy,
    input  logic [RESULT_ADDR_WIDTH-1:0] rd_addr,
    output logic [ACC_WIDTH-1:0]         rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int TW = $clog2(TIMEOUT);

    feeder_state_t state, state_next;

    logic [BUF_ADDR_WIDTH-1:0]    widx;
    logic [BUF_ADDR_WIDTH-1:0]    rd_idx;
    logic [RESULT_ADDR_WIDTH-1:0] ridx;
    logic [TW-1:0]                tcnt;
    logic [ACC_WIDTH-1:0]         result [MAT_DIM];
    logic [DATA_WIDTH-1:0]        buf_word;
    logic                         src_fire, snk_fire;
    logic                         last_w, last_x, last_beat, timed_out;

    assign src_fire  = src_vld && src_rdy;
    assign snk_fire  = snk_vld && snk_rdy;
    assign last_w    = (widx == BUF_ADDR_WIDTH'(W_DEPTH - 1));
    assign last_x    = (widx == BUF_ADDR_WIDTH'(BUF_DEPTH - 1));
    assign last_beat = (ridx == RESULT_ADDR_WIDTH'(MAT_DIM - 1));
    assign timed_out = !snk_fire && (tcnt == TW'(TIMEOUT - 1));
    // Look one word ahead so the next word is ready the cycle after an accept.
    assign rd_idx    = (state == IDLE) ? '0 : widx + 1'b1;
    assign rd_data   = result[rd_addr];

    feeder_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en && (state == IDLE)),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_word (buf_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SEND_W;
            SEND_W:  if (src_fire && last_w) state_next = SEND_X;
            SEND_X:  if (src_fire && last_x) state_next = COLLECT;
            COLLECT: if ((snk_fire && last_beat) || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_vld  <= 1'b0;
            src_data <= '0;
            snk_rdy  <= 1'b0;
            err      <= 1'b0;
            widx     <= '0;
            ridx     <= '0;
            tcnt     <= '0;
            for (int i = 0; i < MAT_DIM; i++) result[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err      <= 1'b0;
                    src_vld  <= 1'b1;
                    src_data <= buf_word;
                    widx     <= '0;
                    ridx     <= '0;
                    for (int i = 0; i < MAT_DIM; i++) result[i] <= '0;
                end
                SEND_W, SEND_X: if (src_fire) begin
                    if (last_x) begin
                        src_vld <= 1'b0;
                        snk_rdy <= 1'b1;
                        tcnt    <= '0;
                    end else begin
                        widx     <= widx + 1'b1;
                        src_data <= buf_word;
                    end
                end
                COLLECT: begin
                    if (snk_fire) begin
                        result[ridx] <= snk_data;
                        ridx         <= ridx + 1'b1;
                        tcnt         <= '0;
                        if (last_beat) snk_rdy <= 1'b0;
                    end else if (timed_out) begin
                        err     <= 1'b1;
                        snk_rdy <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder: stream order, backpressure, wide results, timeout, reset abort.
module tb_matrix_feeder;
    logic        clk = 1'b0;
    logic        rst, wr_en, start, src_rdy, snk_vld;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        src_vld, snk_rdy, busy, done, err;
    logic [7:0]  src_data;
    logic [31:0] snk_data, rd_data;
    logic [1:0]  rd_addr;

    int checks = 0;
    int failures = 0;
    logic [7:0]  exp_stream [20];
    logic [7:0]  got [20];
    logic [31:0] model [4];
    int nb, nc, cnt;

    matrix_feeder #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
        .snk_vld(snk_vld), .snk_data(snk_data), .snk_rdy(snk_rdy),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_job();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_src_vld", 32'(src_vld), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clr", 32'(err), 32'd0);
        check("start_first_word", 32'(src_data), 32'(exp_stream[0]));
    endtask

    // mode 0: src_rdy held high; mode 1: src_rdy toggles every cycle.
    task automatic send(input int mode, input int stop_after, input bit inject,
                        output int n, output int cyc);
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        bit rdy;
        n = 0; cyc = 0;
        while (n < stop_after && cyc < 400) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (stalled) check("stall_stable", 32'(src_data), 32'(held));
            src_rdy  = rdy;
            snk_vld  = inject && (n == 2);
            snk_data = 32'hDEAD_BEEF;
            start    = inject && (n == 17);
            wr_en    = inject && (n == 17);
            wr_addr  = 5'd0;
            wr_data  = 8'h55;
            if (src_vld && rdy) begin
                got[n] = src_data;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = src_vld;
                held    = src_data;
            end
            @(negedge clk);
            cyc++;
        end
        src_rdy = 1'b0; snk_vld = 1'b0; start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic check_stream(input int n);
        for (int i = 0; i < n; i++) check($sformatf("stream_%0d", i), 32'(got[i]), 32'(exp_stream[i]));
    endtask

    // Responder: computes W*X from the words it received and returns n beats.
    task automatic respond(input int n);
        int k = 0;
        int cyc = 0;
        for (int r = 0; r < 4; r++) begin
            model[r] = '0;
            for (int c = 0; c < 4; c++) model[r] += 32'(got[r*4+c]) * 32'(got[16+c]);
        end
        while (k < n && cyc < 200) begin
            snk_vld  = 1'b1;
            snk_data = model[k];
            if (snk_rdy) k++;
            @(negedge clk);
            cyc++;
        end
        snk_vld = 1'b0;
        check("resp_beats", 32'(k), 32'(n));
    endtask

    task automatic read_check(input int a, input logic [31:0] exp_v);
        rd_addr = 2'(a);
        #1;
        check($sformatf("result_%0d", a), rd_data, exp_v);
    endtask

    task automatic finish_check();
        check("done_pulse", 32'(done), 32'd1);
        check("done_err_low", 32'(err), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; src_rdy = 1'b0; snk_vld = 1'b0;
        wr_addr = '0; wr_data = '0; snk_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_src_vld", 32'(src_vld), 32'd0);
        check("rst_src_data", 32'(src_data), 32'd0);
        check("rst_snk_rdy", 32'(snk_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        read_check(0, 32'd0);
        rst = 1'b0;

        // Job 1: identity W, X=[1,2,3,4]; stray start/write in SEND_X and snk_vld in SEND_W
        for (int i = 0; i < 16; i++) begin
            exp_stream[i] = ((i % 5) == 0) ? 8'd1 : 8'd0;
            wr(i, exp_stream[i]);
        end
        for (int i = 0; i < 4; i++) begin
            exp_stream[16+i] = 8'(i + 1);
            wr(16 + i, exp_stream[16+i]);
        end
        wr(20, 8'hAA);
        start_job();
        send(0, 20, 1'b1, nb, nc);
        check("basic_beats", 32'(nb), 32'd20);
        check("basic_cycles", 32'(nc), 32'd20);
        check_stream(20);
        respond(4);
        finish_check();
        for (int a = 0; a < 4; a++) read_check(a, 32'(a + 1));

        // Job 2: same buffers under toggling backpressure
        start_job();
        send(1, 20, 1'b0, nb, nc);
        check("bp_beats", 32'(nb), 32'd20);
        check_stream(20);
        respond(4);
        finish_check();
        for (int a = 0; a < 4; a++) read_check(a, 32'(a + 1));

        // Job 3: all 0xFF -> 4*255*255
        for (int i = 0; i < 20; i++) begin
            exp_stream[i] = 8'hFF;
            wr(i, 8'hFF);
        end
        start_job();
        send(0, 20, 1'b0, nb, nc);
        check_stream(20);
        respond(4);
        finish_check();
        for (int a = 0; a < 4; a++) read_check(a, 32'd260100);

        // Job 4: only 3 result beats -> timeout 64 cycles later
        start_job();
        send(0, 20, 1'b0, nb, nc);
        respond(3);
        cnt = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_latency", 32'(cnt), 32'd64);
        check("timeout_err", 32'(err), 32'd1);
        for (int a = 0; a < 3; a++) read_check(a, 32'd260100);
        read_check(3, 32'd0);
        @(negedge clk);
        check("timeout_done_low", 32'(done), 32'd0);

        // Job 5: ramp buffers; reset after 7 W beats
        for (int i = 0; i < 20; i++) begin
            exp_stream[i] = 8'(i + 1);
            wr(i, exp_stream[i]);
        end
        check("err_sticky", 32'(err), 32'd1);
        start_job();
        send(0, 7, 1'b0, nb, nc);
        check("abort_beats", 32'(nb), 32'd7);
        check_stream(7);
        rst = 1'b1;
        @(negedge clk);
        check("abort_src_vld", 32'(src_vld), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_snk_rdy", 32'(snk_rdy), 32'd0);
        rst = 1'b0;

        // Job 6: re-send from W[0] with intact buffers
        start_job();
        send(0, 20, 1'b0, nb, nc);
        check("resend_beats", 32'(nb), 32'd20);
        check_stream(20);
        respond(4);
        finish_check();
        read_check(0, 32'd190);
        read_check(1, 32'd486);
        read_check(2, 32'd782);
        read_check(3, 32'd1078);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_feeder.md
Name: matrix_feeder

Overview:
- Transmitter/host-side end of the matrix core's stream protocol.
- A host preloads a 4x4 weight matrix W and a 4-element vector X into local buffers, then pulses start.
- The block streams 16 W words (row-major), then 4 X words, over a valid/ready source port.
- It then collects MAT_DIM result beats on a valid/ready sink port into result registers the host can read, and signals done or err.

Parameters:
- DATA_WIDTH, 8, width of W/X words (constants_pkg).
- ACC_WIDTH, 32, width of result words (constants_pkg).
- MAT_DIM, 4, matrix dimension (constants_pkg).
- W_DEPTH, 16, W words per job, MAT_DIM*MAT_DIM (constants_pkg).
- X_DEPTH, 4, X words per job (constants_pkg).
- TIMEOUT, 64, idle cycles allowed between result beats before abort.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- wr_en, input, 1, host buffer write strobe.
- wr_addr, input, 5, buffer address: 0-15 = W row-major, 16-19 = X[0..3].
- wr_data, input, DATA_WIDTH, host write data.
- start, input, 1, job start pulse.
- src_vld, output, 1, outbound word valid.
- src_data, output, DATA_WIDTH, outbound word.
- src_rdy, input, 1, downstream ready.
- snk_vld, input, 1, result beat valid.
- snk_data, input, ACC_WIDTH, result beat.
- snk_rdy, output, 1, result accept ready.
- rd_addr, input, 2, result register select.
- rd_data, output, ACC_WIDTH, result[rd_addr], combinational read.
- busy, output, 1, high outside IDLE.
- done, output, 1, one-cycle completion pulse.
- err, output, 1, sticky timeout flag; cleared on next accepted start.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: src_vld=0, src_data=0, snk_rdy=0, busy=0, done=0, err=0, state=IDLE, counters=0, result regs=0. W/X buffers are not cleared.
- Reset mid-job: abort immediately. src_vld drops the cycle after rst is sampled, and no partial results are retained.
- Transfer rule: a beat moves when vld && rdy are high in the same cycle.
  - src_vld/src_data are registered and held stable until accepted.
  - src_rdy is honoured in the same cycle, with no dependence on src_rdy history.
- States:
  - IDLE:
    - wr_en with wr_addr<20 writes the buffer; wr_addr>=20 is ignored.
    - start: err<=0, busy<=1, src_vld<=1, src_data<=W[0], go to SEND_W.
    - start and wr_en in the same cycle: the write lands first but is not visible to this job's first word if it targets W[0].
  - SEND_W: on each accept, index++ and the next word is presented the next cycle (no bubbles). On accept of W[15], present X[0] and go to SEND_X.
  - SEND_X: on accept of X[3], src_vld<=0, snk_rdy<=1, clear the timeout counter, go to COLLECT.
  - COLLECT:
    - On each accepted beat, result[ridx]<=snk_data, ridx++, clear the timeout counter. Otherwise the timeout counter increments.
    - After the 4th beat: snk_rdy<=0, go to DONE.
    - Timeout counter reaching TIMEOUT-1: err<=1, snk_rdy<=0, go to DONE. Missing results keep their prior (reset/zeroed-at-start) value.
  - DONE: done=1 for one cycle, busy<=0, return to IDLE.
- In all non-IDLE states, wr_en and start are ignored.
- snk_vld while snk_rdy=0 is ignored (no capture).
- Result registers are zeroed on accepted start.
- Latency: first src_vld at start+1. With src_rdy held high, SEND spans 20 cycles. done fires one cycle after the last result is accepted.

Decomposition:
- constants_pkg (existing) holds DATA_WIDTH, ACC_WIDTH, MAT_DIM, W_DEPTH, X_DEPTH.
- Add to constants_pkg: feeder state encoding (IDLE, SEND_W, SEND_X, COLLECT, DONE) and RESULT_ADDR_WIDTH=2.
- One sub-module, feeder_buf: 20xDATA_WIDTH register file with a host write port and an indexed read port.
- The FSM, counters and result registers stay in the top.

Test Plan:
- Basic job:
  - Stimulus: W=identity, X=[1,2,3,4], src_rdy=1, responder model returns [1,2,3,4].
  - Required: 20 src beats in order (16 W then 4 X), rd_data for addr 0..3 = 1,2,3,4, one done pulse, err=0.
- Backpressure:
  - Stimulus: src_rdy toggles 1/0 every cycle.
  - Required: exactly 20 beats in correct order; src_data unchanged during every stall cycle.
- Overflow width:
  - Stimulus: all W and X = 0xFF.
  - Required: every result = 260100 (0x3F804).
- Timeout:
  - Stimulus: responder returns only 3 beats, then stays silent.
  - Required: err=1 and done pulse TIMEOUT cycles after the 3rd beat; result[3]=0; a following start clears err.
- Reset mid-send:
  - Stimulus: rst asserted after 7 W beats accepted.
  - Required: src_vld=0 next cycle, busy=0; the next start re-sends from W[0] with buffers intact.
- Ignored inputs:
  - Stimulus: start pulse and wr_en to addr 0 while in SEND_X; also snk_vld during SEND_W.
  - Required: no restart, W[0] unchanged, no result captured.
